// File: rtl/sensor_poll_scheduler.sv
// sensor_poll_scheduler: round-robin sensor trigger / response-window checker; SENSOR_SCHED_LATENCY_EN adds last_latency
module sensor_poll_scheduler #(
  parameter int N_SENSORS = 4,
  parameter int TIMEOUT_W = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         start,
  input  logic [TIMEOUT_W-1:0]         timeout_lim,
  input  logic [N_SENSORS-1:0]         sensor_resp,
  output logic [N_SENSORS-1:0]         sensor_trig,
  output logic [$clog2(N_SENSORS)-1:0] active_idx,
  output logic [N_SENSORS-1:0]         status_ok,
  output logic [N_SENSORS-1:0]         fault,
  output logic                         alarm,
  output logic                         busy,
  output logic                         sweep_done
`ifdef SENSOR_SCHED_LATENCY_EN
  ,
  output logic [TIMEOUT_W-1:0]         last_latency
`endif
);
  localparam int IW = $clog2(N_SENSORS);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, TRIG, WAIT, GAP} state_t;
  state_t state, nxt;
  logic [IW-1:0] idx_n;
  logic [TIMEOUT_W-1:0] win, cnt;
  logic [GW-1:0] gcnt;
  logic start_q, resp, tmo, gap_end, last;
  // next state and next sensor index; ena low overrides everything back to IDLE
  always_comb begin
    resp = sensor_resp[active_idx];
    tmo = cnt == win;
    gap_end = gcnt == GW'(GAP_CYCLES - 1);
    last = active_idx == IW'(N_SENSORS - 1);
    nxt = state;
    idx_n = active_idx;
    case (state)
      IDLE: if (start) begin
        nxt = TRIG;
        idx_n = '0;
      end
      TRIG: nxt = WAIT;
      WAIT: if (resp || tmo) nxt = GAP;
      GAP: if (gap_end) begin
        idx_n = last ? '0 : active_idx + IW'(1);
        nxt = (!last || start) ? TRIG : IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (!ena) begin
      nxt = IDLE;
      idx_n = '0;
    end
  end
  // registered state, counters and all outputs; per-sensor results update only while enabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      active_idx <= '0;
      sensor_trig <= '0;
      status_ok <= '0;
      fault <= '0;
      alarm <= 1'b0;
      busy <= 1'b0;
      sweep_done <= 1'b0;
      win <= '0;
      cnt <= '0;
      gcnt <= '0;
      start_q <= 1'b0;
`ifdef SENSOR_SCHED_LATENCY_EN
      last_latency <= '0;
`endif
    end else begin
      state <= nxt;
      active_idx <= idx_n;
      start_q <= start;
      sensor_trig <= nxt == TRIG ? N_SENSORS'(1) << idx_n : '0;
      busy <= nxt != IDLE;
      sweep_done <= ena && state == GAP && gap_end && last;
      cnt <= state == WAIT ? cnt + TIMEOUT_W'(1) : '0;
      gcnt <= state == GAP ? gcnt + GW'(1) : '0;
      if (ena) begin
        if (state == TRIG) win <= timeout_lim;
        if (state == IDLE && start && !start_q) alarm <= 1'b0;
        if (state == WAIT && resp) begin
          status_ok[active_idx] <= 1'b1;
          fault[active_idx] <= 1'b0;
`ifdef SENSOR_SCHED_LATENCY_EN
          last_latency <= cnt;
`endif
        end else if (state == WAIT && tmo) begin
          status_ok[active_idx] <= 1'b0;
          fault[active_idx] <= 1'b1;
          alarm <= 1'b1;
`ifdef SENSOR_SCHED_LATENCY_EN
          last_latency <= '1;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// tb_sensor_poll_scheduler: directed bench with a poll-timeline model of sensor_poll_scheduler
module tb_sensor_poll_scheduler;
  localparam int N = 4, TW = 8, GAP = 4;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, start = 1'b0;
  logic [TW-1:0] timeout_lim = '0;
  logic [N-1:0] sensor_resp = '0, sensor_trig, status_ok, fault;
  logic [1:0] active_idx;
  logic alarm, busy, sweep_done;
`ifdef SENSOR_SCHED_LATENCY_EN
  logic [TW-1:0] last_latency;
`endif
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int dly [N] = '{default: -1};
  int since [N] = '{default: 1000};
  bit all_high = 1'b0;
  bit m_run = 1'b0, m_alarm = 1'b0, m_done = 1'b0, m_prev = 1'b0;
  int m_idx = 0, m_t = 0, m_end = 0, m_win = 0, m_lat = 0;
  logic [N-1:0] m_ok = '0, m_fault = '0;

  sensor_poll_scheduler #(.N_SENSORS(N), .TIMEOUT_W(TW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .timeout_lim(timeout_lim),
    .sensor_resp(sensor_resp), .sensor_trig(sensor_trig), .active_idx(active_idx),
    .status_ok(status_ok), .fault(fault), .alarm(alarm), .busy(busy), .sweep_done(sweep_done)
`ifdef SENSOR_SCHED_LATENCY_EN
    , .last_latency(last_latency)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_trig(input logic [N-1:0] v, output int at);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sensor_trig == v) begin
        at = cyc;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    at = cyc;
    $display("FAIL wait_trig: got no pulse in 200 cycles, required trig 0x%0h", v);
  endtask

  // sensors: each answers with a one-cycle pulse dly cycles after its trigger, or all lines held high
  always @(negedge clk)
    for (int i = 0; i < N; i++) begin
      since[i] = sensor_trig[i] ? 0 : since[i] + 1;
      sensor_resp[i] = all_high || (dly[i] >= 0 && since[i] == dly[i]);
    end

  // model: m_t counts cycles since the current trigger, m_end marks the last window cycle
  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_idx = 0; m_t = 0; m_end = 0; m_win = 0;
      m_ok = '0; m_fault = '0; m_alarm = 0; m_done = 0; m_lat = 0;
    end else if (!ena) begin
      m_run = 0; m_idx = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (start && !m_prev) m_alarm = 0;
        if (start) begin m_run = 1; m_idx = 0; m_t = 0; m_end = 0; end
      end else if (m_t == 0) begin
        m_win = int'(timeout_lim);
        m_t = 1;
      end else if (m_end == 0) begin
        if (sensor_resp[m_idx]) begin
          m_ok[m_idx] = 1'b1; m_fault[m_idx] = 1'b0; m_lat = m_t - 1; m_end = m_t;
        end else if (m_t - 1 == m_win) begin
          m_ok[m_idx] = 1'b0; m_fault[m_idx] = 1'b1; m_alarm = 1; m_lat = (1 << TW) - 1; m_end = m_t;
        end
        m_t++;
      end else if (m_t == m_end + GAP) begin
        if (m_idx == N - 1) begin m_done = 1; m_idx = 0; m_run = start; end
        else m_idx++;
        m_t = 0;
        m_end = 0;
      end else m_t++;
    end
    m_prev = rst_n && start;
  end

  // compare every cycle against the model
  always @(negedge clk) begin
    chk("trig", sensor_trig, (m_run && m_t == 0) ? 32'(1) << m_idx : 32'd0);
    chk("trig_onehot", 32'($onehot0(sensor_trig)), 32'd1);
    chk("active_idx", active_idx, m_idx);
    chk("status_ok", status_ok, m_ok);
    chk("fault", fault, m_fault);
    chk("alarm", alarm, m_alarm);
    chk("busy", busy, m_run);
    chk("sweep_done", sweep_done, m_done);
`ifdef SENSOR_SCHED_LATENCY_EN
    chk("last_latency", last_latency, m_lat);
`endif
  end

  initial begin
    int t0, t1, t2, t3, t4;
    tick(2);
    chk("rst_trig", sensor_trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ok", status_ok, 0);
    chk("rst_alarm", alarm, 0);
    // full sweep, every sensor answers 3 cycles after its trigger
    rst_n = 1; timeout_lim = 10; dly = '{default: 3}; start = 1;
    wait_trig(4'h1, t0);
    wait_trig(4'h2, t1); chk("period01", t1 - t0, 8);
    wait_trig(4'h4, t2); chk("period12", t2 - t1, 8);
    wait_trig(4'h8, t3); chk("period23", t3 - t2, 8);
    wait_trig(4'h1, t4); chk("sweep_len", t4 - t0, 32);
    chk("sweep_done_lit", sweep_done, 1);
    chk("ok_all", status_ok, 4'hF);
    chk("fault_none", fault, 0);
    chk("alarm_none", alarm, 0);
    // sensor 2 silent with a 6-sample window
    timeout_lim = 5; dly[2] = -1;
    wait_trig(4'h4, t0);
    tick(6); chk("fault_early", fault, 0);
    tick(1); chk("fault2", fault, 4'h4); chk("alarm_set", alarm, 1); chk("ok_b", status_ok, 4'hB);
    wait_trig(4'h8, t1); chk("after_timeout", t1 - t0, 11);
    // sensor 1 answers on the final sample: response beats timeout
    dly[2] = 3; dly[1] = 6;
    wait_trig(4'h2, t0);
    tick(7);
    chk("late_ok", status_ok, 4'hB); chk("late_fault", fault, 4'h4);
`ifdef SENSOR_SCHED_LATENCY_EN
    chk("latency5", last_latency, 5);
`endif
    wait_trig(4'h4, t1); chk("late_period", t1 - t0, 11);
    // drop start mid-sweep: the sweep finishes then idles
    dly[1] = 3;
    wait_trig(4'h2, t0);
    tick(1); start = 0;
    wait_trig(4'h4, t1); chk("drain12", t1 - t0, 8);
    wait_trig(4'h8, t2); chk("drain23", t2 - t1, 8);
    tick(8);
    chk("drain_done", sweep_done, 1); chk("drain_idle", busy, 0); chk("alarm_kept", alarm, 1);
    tick(2); chk("idle_busy", busy, 0);
    // new run clears alarm; constant responses with a zero window
    timeout_lim = 0; all_high = 1; start = 1;
    tick(1); chk("alarm_clr", alarm, 0); chk("restart_trig", sensor_trig, 4'h1);
    t0 = cyc;
    wait_trig(4'h2, t1); chk("fast01", t1 - t0, 6);
    wait_trig(4'h4, t2); chk("fast12", t2 - t1, 6);
    wait_trig(4'h8, t3); chk("fast23", t3 - t2, 6);
    tick(2); chk("fast_ok", status_ok, 4'hF); chk("fast_fault", fault, 0);
    // reset during a wait window; the pending response lands in IDLE
    all_high = 0; dly = '{default: 5}; timeout_lim = 10;
    wait_trig(4'h2, t0);
    tick(2); rst_n = 0; start = 0;
    tick(1);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_idx", active_idx, 0); chk("mid_rst_ok", status_ok, 0);
    rst_n = 1;
    tick(20);
    chk("post_rst_fault", fault, 0); chk("post_rst_busy", busy, 0);
    // ena low aborts a poll and holds results
    timeout_lim = 10; dly = '{default: 3}; start = 1;
    wait_trig(4'h2, t0);
    tick(1); ena = 0;
    tick(1);
    chk("ena_busy", busy, 0); chk("ena_trig", sensor_trig, 0); chk("ena_idx", active_idx, 0); chk("ena_ok", status_ok, 4'h1);
    ena = 1;
    wait_trig(4'h1, t1); chk("ena_restart", t1 - t0, 3);
    start = 0;
    tick(40);
    chk("final_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sensor_poll_scheduler.md
Name: sensor_poll_scheduler

Overview:
- Round-robin scheduler that sequences the multi-sensor response check datapath.
- Triggers one sensor at a time and waits a programmable window for that sensor's response.
- Records per-sensor pass/fail and raises a sticky alarm on any fault.
- Sits between the top-level pin mapping (start/limit from ui_in, sensor lines on uio) and the status outputs on uo_out.

Parameters:
- N_SENSORS, 4, number of sensors polled (2..8)
- TIMEOUT_W, 8, width of response-window counter and timeout_lim
- GAP_CYCLES, 4, idle cycles between consecutive sensor polls (>=1)

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- ena  input  1  design enable; low forces IDLE
- start  input  1  level; high = run sweeps continuously
- timeout_lim  input  TIMEOUT_W  response window, sampled at each TRIG
- sensor_resp  input  N_SENSORS  per-sensor response lines, active high, synchronous to clk
- sensor_trig  output  N_SENSORS  one-hot single-cycle trigger pulse
- active_idx  output  clog2(N_SENSORS)  sensor currently being polled
- status_ok  output  N_SENSORS  bit i = last poll of sensor i responded in window
- fault  output  N_SENSORS  bit i = last poll of sensor i timed out
- alarm  output  1  sticky OR of all faults since reset or clear
- busy  output  1  high whenever state != IDLE
- sweep_done  output  1  one-cycle pulse after the last sensor's GAP completes

Behaviour:
- All outputs registered. Reset (rst_n=0 at a clk edge): state=IDLE, active_idx=0, sensor_trig=0, status_ok=0, fault=0, alarm=0, busy=0, sweep_done=0, counters=0. Reset mid-poll aborts immediately; no trigger is emitted in the reset cycle.
- FSM states: IDLE, TRIG, WAIT, GAP.
- IDLE:
  - ena&&start -> TRIG with active_idx=0.
  - alarm is cleared only in IDLE, on the cycle start rises from 0 to 1 (new run); status_ok/fault are retained.
- TRIG (1 cycle):
  - sensor_trig[active_idx]=1, all other bits 0.
  - Latch timeout_lim into win, clear wait counter -> WAIT.
- WAIT:
  - Sample only sensor_resp[active_idx]; other bits ignored.
  - Response seen -> status_ok[idx]=1, fault[idx]=0 -> GAP.
  - Else if cnt==win -> fault[idx]=1, status_ok[idx]=0, alarm=1 -> GAP.
  - Else cnt++.
  - Window is win+1 sampled cycles: the first sample is the cycle after the trigger pulse; win=0 gives a single-cycle window.
  - Response and timeout in the same cycle -> response wins (ok).
  - Response already high during TRIG is not counted; it must still be high in WAIT.
- GAP:
  - Count GAP_CYCLES cycles, then advance.
  - If active_idx==N_SENSORS-1: active_idx wraps to 0 and sweep_done pulses for exactly 1 cycle (the first cycle after GAP ends). Next state is TRIG if start is still high, else IDLE.
  - Otherwise active_idx++ -> TRIG.
  - start going low mid-sweep does not abort; the sweep completes and then returns to IDLE.
- ena=0 in any state: next state IDLE, sensor_trig=0, active_idx=0. status_ok, fault and alarm are held. No sweep_done pulse is generated.
- Poll period per sensor: 1 (TRIG) + WAIT cycles + GAP_CYCLES.

Optional Feature:
- Macro: SENSOR_SCHED_LATENCY_EN.
- When defined, adds output last_latency [TIMEOUT_W-1:0].
  - On a response in WAIT it loads the cnt value at that cycle (0 = responded on the first sample).
  - On timeout it loads all-ones.
  - Reset value 0; held while ena=0.
- When undefined, the port and its register are absent; all other behaviour is identical.

Test Plan (N_SENSORS=4, GAP_CYCLES=4, TIMEOUT_W=8):
- Reset, then start=1, timeout_lim=10, every sensor answers 3 cycles after its trigger:
  - sensor_trig pulses 0x1,0x2,0x4,0x8 spaced 1+3+4=8 cycles apart.
  - status_ok=0xF, fault=0, alarm=0; sweep_done pulses once per 32 cycles.
- timeout_lim=5, sensor 2 never responds:
  - fault=0x4 and alarm=1 asserted 6 WAIT cycles after trig[2]; status_ok=0xB.
  - Sweep continues to sensor 3.
- timeout_lim=5, sensor 1 response arrives exactly at cnt==5:
  - Counted ok: status_ok[1]=1, fault[1]=0.
  - With SENSOR_SCHED_LATENCY_EN, last_latency=5.
- sensor_resp=0xF held constantly with timeout_lim=0:
  - Every sensor passes on the first WAIT cycle, giving a 6-cycle poll period.
  - Only one trig bit is high at a time.
- Drop start during sensor 1's WAIT:
  - Sensors 2 and 3 are still polled, sweep_done pulses, then busy=0 in IDLE.
  - Re-raising start clears alarm.
- Assert rst_n=0 for 1 cycle during WAIT:
  - Next cycle all outputs are 0 and state is IDLE.
  - A late response is ignored; no fault is set.
